seg7_scan_reader: RTL and testbench



---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_glyph_decode.sv | 35 +++
 rtl/seg7_scan_reader.sv | 218 +++++++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment read-back path: glyph encodings,
// scan FSM states and the stability counter width.
package seg7_pkg;

  // Active-low {a,b,c,d,e,f,g}: a 0 bit is a lit segment.
  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } seg7_state_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the hex display decoder: 7-bit active-low
// pattern to nibble, with a flag for patterns that are not hex glyphs.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic       legal,
  output logic [3:0] nib
);

  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    case (pat)
      GLYPH_0: nib = 4'h0;
      GLYPH_1: nib = 4'h1;
      GLYPH_2: nib = 4'h2;
      GLYPH_3: nib = 4'h3;
      GLYPH_4: nib = 4'h4;
      GLYPH_5: nib = 4'h5;
      GLYPH_6: nib = 4'h6;
      GLYPH_7: nib = 4'h7;
      GLYPH_8: nib = 4'h8;
      GLYPH_9: nib = 4'h9;
      GLYPH_A: nib = 4'hA;
      GLYPH_B: nib = 4'hB;
      GLYPH_C: nib = 4'hC;
      GLYPH_D: nib = 4'hD;
      GLYPH_E: nib = 4'hE;
      GLYPH_F: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus with
// per-slot stability filtering. Define SEG7_RD_DP_EN to capture decimal points.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic                  dp_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
`ifdef SEG7_RD_DP_EN
  output logic [DIGITS-1:0]     dp,
`endif
  output logic                  update,
  output logic                  err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef SEG7_RD_DP_EN
  localparam int PAT_W = 8;
`else
  localparam int PAT_W = 7;
`endif
  localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CNT);

  // Input registers; reset to blank segments and no digit selected.
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
`ifdef SEG7_RD_DP_EN
  logic              dpn_q, dpn_d;
`else
  logic              unused_dp;
  assign unused_dp = dp_n;
`endif

  seg7_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAT_W-1:0]  pat_q, pat_d;

  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic                update_q, update_d;
  logic                err_q, err_d;
`ifdef SEG7_RD_DP_EN
  logic [DIGITS-1:0]   dp_cap_q, dp_cap_d;
`endif

  logic [3:0]        zeros;
  logic [IDX_W-1:0]  sel_idx;
  logic              single_sel;
  logic [PAT_W-1:0]  sample_pat;
  logic              same;
  logic              commit;
  logic              legal;
  logic [3:0]        nib;
  logic [3:0]        nib_cur;

  always_comb begin
    seg_d = seg_n;
    an_d  = an_n;
  end
`ifdef SEG7_RD_DP_EN
  always_comb dpn_d = dp_n;
  assign sample_pat = {dpn_q, seg_q};
`else
  assign sample_pat = seg_q;
`endif

  // A slot is only meaningful when exactly one anode is driven low.
  always_comb begin
    zeros   = '0;
    sel_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) begin
        zeros   = zeros + 4'd1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign single_sel = (zeros == 4'd1);
  assign same       = single_sel && (sel_idx == idx_q) && (sample_pat == pat_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (single_sel) begin
          state_d = TRACK;
          idx_d   = sel_idx;
          pat_d   = sample_pat;
          cnt_d   = 4'd1;
        end
      end
      TRACK: begin
        if (!single_sel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (same) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == STABLE_V) begin
            commit  = 1'b1;
            state_d = HOLD;
          end
        end else begin
          idx_d = sel_idx;
          pat_d = sample_pat;
          cnt_d = 4'd1;
        end
      end
      HOLD: begin
        // Leaving HOLD starts the next slot in the same cycle (no bubble).
        if (!same) begin
          if (single_sel) begin
            state_d = TRACK;
            idx_d   = sel_idx;
            pat_d   = sample_pat;
            cnt_d   = 4'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  seg7_glyph_decode u_decode (
    .pat   (pat_q[6:0]),
    .legal (legal),
    .nib   (nib)
  );

  assign nib_cur = value_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    value_d  = value_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    err_d    = 1'b0;
`ifdef SEG7_RD_DP_EN
    dp_cap_d = dp_cap_q;
`endif
    if (commit) begin
      if (legal) begin
        value_d[{idx_q, 2'b00} +: 4] = nib;
        valid_d[idx_q]               = 1'b1;
        update_d                     = !valid_q[idx_q] || (nib_cur != nib);
`ifdef SEG7_RD_DP_EN
        dp_cap_d[idx_q]              = ~pat_q[7];
`endif
      end else begin
        // Illegal glyph invalidates the digit but keeps the last good nibble.
        err_d          = 1'b1;
        valid_d[idx_q] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= '1;
      an_q     <= '1;
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      pat_q    <= '1;
      value_q  <= '0;
      valid_q  <= '0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      seg_q    <= seg_d;
      an_q     <= an_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

`ifdef SEG7_RD_DP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dpn_q    <= 1'b1;
      dp_cap_q <= '0;
    end else begin
      dpn_q    <= dpn_d;
      dp_cap_q <= dp_cap_d;
    end
  end
  assign dp = dp_cap_q;
`endif

  assign value       = value_q;
  assign digit_valid = valid_q;
  assign update      = update_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: run-length reference model plus directed scans.
// Build with SEG7_RD_DP_EN defined to also cover decimal-point capture.
module tb_seg7_scan_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [6:0]          seg_n = 7'h7F;
  logic                dp_n = 1'b1;
  logic [DIGITS-1:0]   an_n = '1;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   digit_valid;
  logic                update;
  logic                err;
`ifdef SEG7_RD_DP_EN
  logic [DIGITS-1:0]   dp;
`endif

  seg7_scan_reader #(.DIGITS(DIGITS), .STABLE_CNT(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n),
    .value       (value),
    .digit_valid (digit_valid),
`ifdef SEG7_RD_DP_EN
    .dp          (dp),
`endif
    .update      (update),
    .err         (err)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int checks = 0;
  int passes = 0;
  int upd_seen = 0;
  int err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a digit commits when the same single-select sample
  // has been seen on exactly STABLE consecutive registered cycles.
  int                exp_nib [DIGITS];
  bit                exp_vld [DIGITS];
  bit                exp_dpv [DIGITS];
  bit                exp_upd, exp_err;
  int                run;
  bit                have_last;
  logic [DIGITS+7:0] last_key, key;
  logic [DIGITS-1:0] p_an, s_an;
  logic [6:0]        p_seg, s_seg;
  logic              p_dp, s_dp;

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) begin
      exp_nib[i] = 0;
      exp_vld[i] = 0;
      exp_dpv[i] = 0;
    end
    exp_upd   = 0;
    exp_err   = 0;
    run       = 0;
    have_last = 0;
    p_an      = '1;
    p_seg     = 7'h7F;
    p_dp      = 1'b1;
  endtask

  function automatic logic [4*DIGITS-1:0] exp_value_vec();
    logic [4*DIGITS-1:0] v;
    v = '0;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = exp_nib[i][3:0];
    return v;
  endfunction

  function automatic logic [DIGITS-1:0] exp_valid_vec();
    logic [DIGITS-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[i] = exp_vld[i];
    return v;
  endfunction

  function automatic logic [DIGITS-1:0] exp_dp_vec();
    logic [DIGITS-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[i] = exp_dpv[i];
    return v;
  endfunction

  initial begin : model
    int idx;
    int hit;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        s_an  = p_an;
        s_seg = p_seg;
        s_dp  = p_dp;
        p_an  = an_n;
        p_seg = seg_n;
        p_dp  = dp_n;
        exp_upd = 0;
        exp_err = 0;
`ifdef SEG7_RD_DP_EN
        key = {s_an, s_dp, s_seg};
`else
        key = {s_an, 1'b0, s_seg};
`endif
        if ($countones(~s_an) == 1) begin
          if (have_last && key == last_key) run++;
          else run = 1;
          last_key  = key;
          have_last = 1;
        end else begin
          run       = 0;
          have_last = 0;
        end
        if (run == STABLE) begin
          idx = 0;
          for (int i = 0; i < DIGITS; i++) if (!s_an[i]) idx = i;
          hit = -1;
          for (int g = 0; g < 16; g++) if (glyph_tab[g] == s_seg) hit = g;
          if (hit >= 0) begin
            exp_upd      = !exp_vld[idx] || (exp_nib[idx] != hit);
            exp_nib[idx] = hit;
            exp_vld[idx] = 1;
            exp_dpv[idx] = !s_dp;
          end else begin
            exp_err      = 1;
            exp_vld[idx] = 0;
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      check("value", 32'(value), 32'(exp_value_vec()));
      check("digit_valid", 32'(digit_valid), 32'(exp_valid_vec()));
      check("update", 32'(update), 32'(exp_upd));
      check("err", 32'(err), 32'(exp_err));
`ifdef SEG7_RD_DP_EN
      check("dp", 32'(dp), 32'(exp_dp_vec()));
`endif
      if (update) upd_seen++;
      if (err) err_seen++;
    end
  end

  task automatic show(input logic [DIGITS-1:0] an, input logic [6:0] seg,
                      input logic dpn, input int n);
    an_n  = an;
    seg_n = seg;
    dp_n  = dpn;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_four();
    show(4'b1110, glyph_tab[3],  1'b1, 8);
    show(4'b1101, glyph_tab[11], 1'b1, 8);
    show(4'b1011, glyph_tab[12], 1'b1, 8);
    show(4'b0111, glyph_tab[15], 1'b1, 8);
  endtask

  initial begin : stim
    int u0;
    int e0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_value", 32'(value), 32'h0);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_update", 32'(update), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_value", 32'(value), 32'h0);
    check("idle_valid", 32'(digit_valid), 32'h0);
    check("idle_updates", 32'(upd_seen), 32'h0);
    check("idle_errs", 32'(err_seen), 32'h0);

    an_n  = 4'b1110;
    seg_n = glyph_tab[2];
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1 check("latency_update", 32'(update), (k == 4) ? 32'h1 : 32'h0);
    end
    repeat (6) @(negedge clk);
    check("digit0_nibble", 32'(value[3:0]), 32'h2);
    check("digit0_valid", 32'(digit_valid), 32'h1);

    u0 = upd_seen;
    scan_four();
    check("scan_value", 32'(value), 32'hFCB3);
    check("scan_updates", 32'(upd_seen - u0), 32'd4);
    check("scan_valid", 32'(digit_valid), 32'hF);
    u0 = upd_seen;
    scan_four();
    check("rescan_updates", 32'(upd_seen - u0), 32'd0);

    u0 = upd_seen;
    e0 = err_seen;
    show(4'b1101, glyph_tab[11], 1'b1, 8);
    show(4'b1101, 7'b0000000,    1'b1, 2);
    show(4'b1101, glyph_tab[11], 1'b1, 8);
    check("glitch_value", 32'(value), 32'hFCB3);
    check("glitch_updates", 32'(upd_seen - u0), 32'd0);
    check("glitch_errs", 32'(err_seen - e0), 32'd0);

    e0 = err_seen;
    show(4'b1011, 7'b1111111, 1'b1, 8);
    check("illegal_errs", 32'(err_seen - e0), 32'd1);
    check("illegal_valid", 32'(digit_valid), 32'hB);
    check("illegal_keeps_nibble", 32'(value[11:8]), 32'hC);
    u0 = upd_seen;
    show(4'b1011, glyph_tab[12], 1'b1, 8);
    check("recover_valid", 32'(digit_valid), 32'hF);
    check("recover_updates", 32'(upd_seen - u0), 32'd1);

    u0 = upd_seen;
    e0 = err_seen;
    show(4'b1100, glyph_tab[0], 1'b1, 10);
    check("multisel_value", 32'(value), 32'hFCB3);
    check("multisel_updates", 32'(upd_seen - u0), 32'd0);
    check("multisel_errs", 32'(err_seen - e0), 32'd0);

    an_n  = 4'b1110;
    seg_n = glyph_tab[5];
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_value", 32'(value), 32'h0);
    check("midrst_valid", 32'(digit_valid), 32'h0);
    check("midrst_update", 32'(update), 32'h0);
    check("midrst_err", 32'(err), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1 check("post_reset_latency", 32'(update), (k == 4) ? 32'h1 : 32'h0);
    end
    repeat (2) @(negedge clk);
    check("post_reset_value", 32'(value), 32'h0005);
    check("post_reset_valid", 32'(digit_valid), 32'h1);

`ifdef SEG7_RD_DP_EN
    show(4'b1110, glyph_tab[1], 1'b0, 8);
    check("dp_set", 32'(dp), 32'h1);
    check("dp_nibble", 32'(value[3:0]), 32'h1);
    u0 = upd_seen;
    show(4'b1110, glyph_tab[1], 1'b1, 8);
    check("dp_clear", 32'(dp), 32'h0);
    check("dp_no_update", 32'(upd_seen - u0), 32'd0);
`endif

    show(4'b1111, 7'h7F, 1'b1, 4);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
